sv32_tlb_plru: RTL and testbench

Parametrised fully-associative Sv32 TLB. It replaces the fixed 4-entry TLB in the CVA6 MMU path. Adds configurable depth, configurable ASID width, tree pseudo-LRU replacement with invalid-first fill, in-place refresh of duplicate tags, full SFENCE.VMA flush semantics, and an optional registered lookup stage. It sits between the PTW (update side) and the I/D MMU translation logic (lookup side).

---
 rtl/sv32_tlb_plru.sv | 279 +++++++++++++++++++++++++++
 tb/tb_sv32_tlb_plru.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sv32_tlb_plru.sv
// ---------------------------------------------------------------------------
// sv32_tlb_plru
//
// Fully-associative Sv32 TLB with tree pseudo-LRU replacement. The PTW
// refills it through the update port; the I/D MMU translation logic queries
// it through the lookup port. SFENCE.VMA is handled by the flush port.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   flush_i             SFENCE.VMA strobe
//   flush_asid_i        ASID to flush (0 = all ASIDs)
//   flush_vaddr_i       vaddr to flush (0 = all addresses)
//   upd_valid_i         PTW refill strobe
//   upd_is_4M_i         refill is a 4 MiB superpage
//   upd_vpn_i           refill VPN {vpn1, vpn0}
//   upd_asid_i          refill ASID
//   upd_content_i       refill Sv32 PTE (bit 5 = G)
//   lu_access_i         lookup request
//   lu_asid_i           lookup ASID
//   lu_vaddr_i          lookup virtual address
//   lu_hit_o            lookup hit
//   lu_is_4M_o          hit entry is a superpage
//   lu_content_o        hit entry PTE, 0 when no hit
//   replace_idx_o       entry the next refill would go to (if not a duplicate)
//   valid_o             per-entry valid bits
//
// REG_LOOKUP = 0 gives combinational lookup outputs; REG_LOOKUP = 1 adds one
// register stage on the lookup outputs.
// ---------------------------------------------------------------------------
module sv32_tlb_plru #(
  parameter int unsigned ENTRIES    = 4,
  parameter int unsigned ASID_WIDTH = 9,
  parameter int unsigned REG_LOOKUP = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic [ASID_WIDTH-1:0]      flush_asid_i,
  input  logic [31:0]                flush_vaddr_i,
  input  logic                       upd_valid_i,
  input  logic                       upd_is_4M_i,
  input  logic [19:0]                upd_vpn_i,
  input  logic [ASID_WIDTH-1:0]      upd_asid_i,
  input  logic [31:0]                upd_content_i,
  input  logic                       lu_access_i,
  input  logic [ASID_WIDTH-1:0]      lu_asid_i,
  input  logic [31:0]                lu_vaddr_i,
  output logic                       lu_hit_o,
  output logic                       lu_is_4M_o,
  output logic [31:0]                lu_content_o,
  output logic [$clog2(ENTRIES)-1:0] replace_idx_o,
  output logic [ENTRIES-1:0]         valid_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned NODES = ENTRIES - 1;

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  logic [ENTRIES-1:0]    valid_q, valid_d;
  logic [NODES-1:0]      plru_q, plru_d;
  logic [9:0]            vpn1_q    [ENTRIES];
  logic [9:0]            vpn1_d    [ENTRIES];
  logic [9:0]            vpn0_q    [ENTRIES];
  logic [9:0]            vpn0_d    [ENTRIES];
  logic [ASID_WIDTH-1:0] asid_q    [ENTRIES];
  logic [ASID_WIDTH-1:0] asid_d    [ENTRIES];
  logic                  is_4m_q   [ENTRIES];
  logic                  is_4m_d   [ENTRIES];
  logic [31:0]           content_q [ENTRIES];
  logic [31:0]           content_d [ENTRIES];

  // Page offset of the lookup address never takes part in matching.
  logic unused_lu_offset;
  assign unused_lu_offset = ^lu_vaddr_i[11:0];

  // ------------------------------------------------------------------------
  // PLRU tree helper. Nodes are heap-ordered: node n has children 2n+1 and
  // 2n+2, root is node 0. A node bit of 0 means the victim lies in its lower
  // half. Touching an entry points every node on its path away from it.
  // ------------------------------------------------------------------------
  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                  input logic [IDX_W-1:0] idx);
    logic [NODES-1:0] r;
    int node;
    r = bits;
    for (int l = 0; l < IDX_W; l++) begin
      // The first l index bits (MSB first) select the node at depth l.
      node = (1 << l) - 1 + int'(idx >> (IDX_W - l));
      r[node] = ~idx[IDX_W-1-l];
    end
    return r;
  endfunction

  // ------------------------------------------------------------------------
  // Per-entry comparators
  // ------------------------------------------------------------------------
  logic [ENTRIES-1:0] lu_match;
  logic [ENTRIES-1:0] upd_dup;
  logic [ENTRIES-1:0] flush_hit;
  logic               flush_asid_zero;
  logic               flush_vaddr_zero;

  assign flush_asid_zero  = (flush_asid_i == '0);
  assign flush_vaddr_zero = (flush_vaddr_i == '0);

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    logic is_global;
    logic lu_asid_eq;
    logic lu_vpn_eq;
    logic flush_asid_eq;
    logic flush_vpn_eq;

    assign is_global     = content_q[gi][5];
    assign lu_asid_eq    = (asid_q[gi] == lu_asid_i);
    assign lu_vpn_eq     = (vpn1_q[gi] == lu_vaddr_i[31:22]) &&
                           (is_4m_q[gi] || (vpn0_q[gi] == lu_vaddr_i[21:12]));
    assign flush_asid_eq = (asid_q[gi] == flush_asid_i);
    assign flush_vpn_eq  = (vpn1_q[gi] == flush_vaddr_i[31:22]) &&
                           (is_4m_q[gi] || (vpn0_q[gi] == flush_vaddr_i[21:12]));

    assign lu_match[gi] = valid_q[gi] && (lu_asid_eq || is_global) && lu_vpn_eq;

    // Same tag as the refill: refresh in place instead of allocating a copy.
    assign upd_dup[gi] = valid_q[gi] &&
                         (vpn1_q[gi] == upd_vpn_i[19:10]) &&
                         (upd_is_4M_i || (vpn0_q[gi] == upd_vpn_i[9:0])) &&
                         (asid_q[gi] == upd_asid_i) &&
                         (is_4m_q[gi] == upd_is_4M_i);

    // Global entries survive every ASID-qualified flush.
    assign flush_hit[gi] = flush_asid_zero
                         ? (flush_vaddr_zero || flush_vpn_eq)
                         : (!is_global && flush_asid_eq &&
                            (flush_vaddr_zero || flush_vpn_eq));
  end

  // ------------------------------------------------------------------------
  // Priority encoders (lowest index wins) and victim selection
  // ------------------------------------------------------------------------
  logic [IDX_W-1:0] hit_idx;
  logic [IDX_W-1:0] dup_idx;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] tree_idx;
  logic [IDX_W-1:0] replace_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             any_free;
  logic             dup_found;

  always_comb begin
    hit_idx  = '0;
    dup_idx  = '0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (lu_match[i]) hit_idx  = IDX_W'(i);
      if (upd_dup[i])  dup_idx  = IDX_W'(i);
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  // Walk from the root following each node's victim direction.
  always_comb begin
    int node;
    node     = 0;
    tree_idx = '0;
    for (int l = 0; l < IDX_W; l++) begin
      tree_idx[IDX_W-1-l] = plru_q[node];
      node = 2 * node + 1 + int'(plru_q[node]);
    end
  end

  assign any_free    = ~&valid_q;
  assign dup_found   = |upd_dup;
  assign replace_idx = any_free ? free_idx : tree_idx;
  assign upd_idx     = dup_found ? dup_idx : replace_idx;

  // ------------------------------------------------------------------------
  // Lookup result from pre-clock state
  // ------------------------------------------------------------------------
  logic        lu_hit_c;
  logic        lu_is_4m_c;
  logic [31:0] lu_content_c;

  assign lu_hit_c     = lu_access_i && (|lu_match);
  assign lu_is_4m_c   = lu_hit_c && is_4m_q[hit_idx];
  assign lu_content_c = lu_hit_c ? content_q[hit_idx] : 32'h0;

  // ------------------------------------------------------------------------
  // Next-state: lookup touch, then flush or refill
  // ------------------------------------------------------------------------
  always_comb begin
    valid_d   = valid_q;
    plru_d    = plru_q;
    vpn1_d    = vpn1_q;
    vpn0_d    = vpn0_q;
    asid_d    = asid_q;
    is_4m_d   = is_4m_q;
    content_d = content_q;

    if (lu_hit_c && !flush_i) begin
      plru_d = plru_touch(plru_d, hit_idx);
    end

    if (flush_i) begin
      // A flush wins over a same-cycle refill, and leaves the tree alone.
      valid_d = valid_q & ~flush_hit;
    end else if (upd_valid_i) begin
      valid_d[upd_idx]   = 1'b1;
      vpn1_d[upd_idx]    = upd_vpn_i[19:10];
      vpn0_d[upd_idx]    = upd_vpn_i[9:0];
      asid_d[upd_idx]    = upd_asid_i;
      is_4m_d[upd_idx]   = upd_is_4M_i;
      content_d[upd_idx] = upd_content_i;
      // Applied after the lookup touch so the refilled entry is protected.
      plru_d = plru_touch(plru_d, upd_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      plru_q  <= '0;
    end else begin
      valid_q <= valid_d;
      plru_q  <= plru_d;
    end
  end

  // Payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    vpn1_q    <= vpn1_d;
    vpn0_q    <= vpn0_d;
    asid_q    <= asid_d;
    is_4m_q   <= is_4m_d;
    content_q <= content_d;
  end

  assign valid_o       = valid_q;
  assign replace_idx_o = replace_idx;

  // ------------------------------------------------------------------------
  // Lookup output stage
  // ------------------------------------------------------------------------
  if (REG_LOOKUP != 0) begin : g_reg_lookup
    logic        lu_hit_q, lu_hit_d;
    logic        lu_is_4m_q, lu_is_4m_d;
    logic [31:0] lu_content_q, lu_content_d;

    // A result computed alongside a flush may refer to an entry being
    // invalidated, so it is suppressed.
    always_comb begin
      lu_hit_d     = lu_hit_c && !flush_i;
      lu_is_4m_d   = lu_is_4m_c && !flush_i;
      lu_content_d = flush_i ? 32'h0 : lu_content_c;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        lu_hit_q     <= 1'b0;
        lu_is_4m_q   <= 1'b0;
        lu_content_q <= 32'h0;
      end else begin
        lu_hit_q     <= lu_hit_d;
        lu_is_4m_q   <= lu_is_4m_d;
        lu_content_q <= lu_content_d;
      end
    end

    assign lu_hit_o     = lu_hit_q;
    assign lu_is_4M_o   = lu_is_4m_q;
    assign lu_content_o = lu_content_q;
  end else begin : g_comb_lookup
    assign lu_hit_o     = lu_hit_c;
    assign lu_is_4M_o   = lu_is_4m_c;
    assign lu_content_o = lu_content_c;
  end

endmodule

// File: tb/tb_sv32_tlb_plru.sv
// ---------------------------------------------------------------------------
// tb_sv32_tlb_plru
//
// Directed bench for sv32_tlb_plru with ENTRIES=4, ASID_WIDTH=9. Two copies
// share all inputs: dut (combinational lookup) and dut_r (registered lookup).
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
// PLRU bits are written below as {n0 root, n1 (entries 0/1), n2 (entries 2/3)}.
// ---------------------------------------------------------------------------
module tb_sv32_tlb_plru;

  logic        clk;
  logic        reset;
  logic        flush_i;
  logic [8:0]  flush_asid_i;
  logic [31:0] flush_vaddr_i;
  logic        upd_valid_i;
  logic        upd_is_4M_i;
  logic [19:0] upd_vpn_i;
  logic [8:0]  upd_asid_i;
  logic [31:0] upd_content_i;
  logic        lu_access_i;
  logic [8:0]  lu_asid_i;
  logic [31:0] lu_vaddr_i;

  logic        hit, is4m;
  logic [31:0] content;
  logic [1:0]  ridx;
  logic [3:0]  valid;
  logic        hit_r, is4m_r;
  logic [31:0] content_r;
  logic [1:0]  ridx_r;
  logic [3:0]  valid_r;

  int checks = 0;
  int errors = 0;

  sv32_tlb_plru #(.ENTRIES(4), .ASID_WIDTH(9), .REG_LOOKUP(0)) dut (
    .clk(clk), .reset(reset),
    .flush_i(flush_i), .flush_asid_i(flush_asid_i), .flush_vaddr_i(flush_vaddr_i),
    .upd_valid_i(upd_valid_i), .upd_is_4M_i(upd_is_4M_i), .upd_vpn_i(upd_vpn_i),
    .upd_asid_i(upd_asid_i), .upd_content_i(upd_content_i),
    .lu_access_i(lu_access_i), .lu_asid_i(lu_asid_i), .lu_vaddr_i(lu_vaddr_i),
    .lu_hit_o(hit), .lu_is_4M_o(is4m), .lu_content_o(content),
    .replace_idx_o(ridx), .valid_o(valid)
  );

  sv32_tlb_plru #(.ENTRIES(4), .ASID_WIDTH(9), .REG_LOOKUP(1)) dut_r (
    .clk(clk), .reset(reset),
    .flush_i(flush_i), .flush_asid_i(flush_asid_i), .flush_vaddr_i(flush_vaddr_i),
    .upd_valid_i(upd_valid_i), .upd_is_4M_i(upd_is_4M_i), .upd_vpn_i(upd_vpn_i),
    .upd_asid_i(upd_asid_i), .upd_content_i(upd_content_i),
    .lu_access_i(lu_access_i), .lu_asid_i(lu_asid_i), .lu_vaddr_i(lu_vaddr_i),
    .lu_hit_o(hit_r), .lu_is_4M_o(is4m_r), .lu_content_o(content_r),
    .replace_idx_o(ridx_r), .valid_o(valid_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [19:0] vpn, input logic [8:0] asid,
                           input logic [31:0] pte, input logic is4m_in);
    upd_vpn_i     = vpn;
    upd_asid_i    = asid;
    upd_content_i = pte;
    upd_is_4M_i   = is4m_in;
    upd_valid_i   = 1'b1;
    tick();
    upd_valid_i   = 1'b0;
    $display("update vpn=%05h asid=%0d pte=%08h 4M=%0b -> valid=%04b", vpn, asid, pte, is4m_in, valid);
  endtask

  task automatic do_flush(input logic [8:0] asid, input logic [31:0] vaddr);
    flush_asid_i  = asid;
    flush_vaddr_i = vaddr;
    flush_i       = 1'b1;
    tick();
    flush_i       = 1'b0;
    $display("flush asid=%0d vaddr=%08h -> valid=%04b", asid, vaddr, valid);
  endtask

  // Leaves lu_access_i high; the caller lowers it unless a touch is wanted.
  task automatic probe(input logic [31:0] vaddr, input logic [8:0] asid);
    lu_vaddr_i  = vaddr;
    lu_asid_i   = asid;
    lu_access_i = 1'b1;
    #1;
    $display("lookup vaddr=%08h asid=%0d -> hit=%0b 4M=%0b pte=%08h", vaddr, asid, hit, is4m, content);
  endtask

  initial begin
    reset = 1'b1;
    flush_i = 1'b0; flush_asid_i = '0; flush_vaddr_i = '0;
    upd_valid_i = 1'b0; upd_is_4M_i = 1'b0; upd_vpn_i = '0; upd_asid_i = '0; upd_content_i = '0;
    lu_access_i = 1'b0; lu_asid_i = '0; lu_vaddr_i = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    probe(32'h12345000, 9'd1);
    check("rst_hit", hit, 0);
    check("rst_content", content, 0);
    check("rst_valid", valid, 4'b0000);
    check("rst_ridx", ridx, 0);
    check("rst_reg_hit", hit_r, 0);
    check("rst_reg_content", content_r, 0);
    lu_access_i = 1'b0;

    // First refill -> entry 0, plru {1,1,0}
    do_update(20'h12345, 9'd1, 32'h000ABC0F, 1'b0);
    probe(32'h12345678, 9'd1);
    check("e0_hit", hit, 1);
    check("e0_content", content, 32'h000ABC0F);
    check("e0_is4m", is4m, 0);
    check("e0_valid", valid, 4'b0001);
    check("e0_ridx", ridx, 1);
    probe(32'h12345678, 9'd2);
    check("e0_other_asid_hit", hit, 0);
    check("e0_other_asid_content", content, 0);
    probe(32'h12345678, 9'd1);
    tick();
    check("reg_hit_n1", hit_r, 1);
    check("reg_content_n1", content_r, 32'h000ABC0F);
    lu_access_i = 1'b0;

    // Global 4 MiB superpage -> entry 1, plru {1,0,0}
    do_update(20'h04800, 9'd3, 32'h0000002F, 1'b1);
    probe(32'h04BFF000, 9'd7);
    check("sp_hit", hit, 1);
    check("sp_is4m", is4m, 1);
    check("sp_content", content, 32'h0000002F);
    probe(32'h04BFF000, 9'h1FF);
    check("sp_any_asid_hit", hit, 1);
    lu_access_i = 1'b0;
    check("sp_valid", valid, 4'b0011);

    // Fill entries 2 and 3 -> plru {0,0,0}
    do_update(20'h00002, 9'd1, 32'h00000201, 1'b0);
    check("fill2_valid", valid, 4'b0111);
    do_update(20'h00003, 9'd1, 32'h00000301, 1'b0);
    check("fill3_valid", valid, 4'b1111);
    check("full_ridx", ridx, 0);

    // Touch entry 0 then entry 2 -> plru {0,1,1}, victim 1
    probe(32'h12345000, 9'd1);
    tick();
    probe(32'h00002000, 9'd1);
    check("e2_content", content, 32'h00000201);
    tick();
    lu_access_i = 1'b0;
    check("plru_ridx_1", ridx, 1);

    // New tag replaces entry 1 -> plru {1,0,1}, victim 3
    do_update(20'h00004, 9'd1, 32'h00000401, 1'b0);
    probe(32'h00004000, 9'd1);
    check("e1_new_content", content, 32'h00000401);
    probe(32'h04BFF000, 9'd7);
    check("sp_evicted_hit", hit, 0);
    lu_access_i = 1'b0;
    check("plru_ridx_3", ridx, 3);

    // Touch entry 3 -> plru {0,0,0}, victim 0
    probe(32'h00003000, 9'd1);
    tick();
    lu_access_i = 1'b0;
    check("plru_ridx_0", ridx, 0);

    // Duplicate tag refreshes entry 3 in place, entry 0 untouched
    do_update(20'h00003, 9'd1, 32'h000003FF, 1'b0);
    probe(32'h00003000, 9'd1);
    check("dup_content", content, 32'h000003FF);
    probe(32'h12345000, 9'd1);
    check("dup_e0_kept", content, 32'h000ABC0F);
    lu_access_i = 1'b0;
    check("dup_valid", valid, 4'b1111);
    check("dup_ridx", ridx, 0);

    // Flush everything
    do_flush(9'd0, 32'h0);
    check("flush_all_valid", valid, 4'b0000);

    // asid1 G=0, asid1 G=1, asid2
    do_update(20'h00010, 9'd1, 32'h00000011, 1'b0);
    do_update(20'h00011, 9'd1, 32'h00000031, 1'b0);
    do_update(20'h00012, 9'd2, 32'h00000012, 1'b0);
    check("fl_fill_valid", valid, 4'b0111);
    do_flush(9'd1, 32'h0);
    check("fl_asid_valid", valid, 4'b0110);
    check("fl_asid_ridx", ridx, 0);

    // Flush with same-cycle refill: refill dropped
    upd_vpn_i = 20'h00020; upd_asid_i = 9'd1; upd_content_i = 32'h00000020; upd_is_4M_i = 1'b0;
    upd_valid_i = 1'b1;
    do_flush(9'd5, 32'h12340000);
    upd_valid_i = 1'b0;
    check("fl_upd_valid", valid, 4'b0110);
    probe(32'h00020000, 9'd1);
    check("fl_upd_hit", hit, 0);
    lu_access_i = 1'b0;

    // Address-only flush, then asid+address flush that spares a global entry
    do_flush(9'd0, 32'h00012000);
    check("fl_vaddr_valid", valid, 4'b0010);
    do_flush(9'd1, 32'h00011000);
    check("fl_global_kept", valid, 4'b0010);

    // Registered lookup: hit, then flush-gated, then reset
    probe(32'h00011000, 9'd9);
    check("g_hit", hit, 1);
    tick();
    check("reg_hit", hit_r, 1);
    check("reg_content", content_r, 32'h00000031);
    flush_asid_i = 9'd3; flush_vaddr_i = 32'h00011000; flush_i = 1'b1;
    #1;
    check("flush_cycle_comb_hit", hit, 1);
    tick();
    flush_i = 1'b0;
    check("reg_flush_hit", hit_r, 0);
    check("reg_flush_content", content_r, 0);
    check("reg_flush_valid", valid, 4'b0010);
    tick();
    check("reg_hit_again", hit_r, 1);
    reset = 1'b1;
    upd_vpn_i = 20'h00030; upd_asid_i = 9'd1; upd_content_i = 32'h00000030; upd_is_4M_i = 1'b1;
    upd_valid_i = 1'b1;
    tick();
    reset = 1'b0;
    upd_valid_i = 1'b0;
    lu_access_i = 1'b0;
    $display("reset cycle -> reg hit=%0b pte=%08h valid=%04b", hit_r, content_r, valid_r);
    check("rst2_reg_hit", hit_r, 0);
    check("rst2_reg_content", content_r, 0);
    check("rst2_reg_is4m", is4m_r, 0);
    check("rst2_reg_valid", valid_r, 4'b0000);
    check("rst2_reg_ridx", ridx_r, 0);
    check("rst2_valid", valid, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
